// File: rtl/gnr_attractor_ctrl.sv
// Attractor search controller for a gene-regulatory node network: Floyd-style
// tortoise/hare walk to the first meet, then a hare-only lap to measure the period.
module gnr_attractor_ctrl #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               seed_valid,
    output logic               seed_ready,
    input  logic [N_NODES-1:0] seed,
    input  logic               abort,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   res_meet,
    output logic [CNT_W-1:0]   res_period,
    output logic               res_timeout,
    output logic [N_NODES-1:0] res_seed
);

    // state  | meaning
    // IDLE   | waiting for a seed, seed_ready high
    // LOAD   | one cycle of reset_nos pushing init_state into every node
    // WALK   | hare runs at full rate, tortoise at half rate, until an even-step meet
    // PERIOD | tortoise parked, hare laps the attractor counting cycles
    // DONE   | result presented, waiting for res_ready
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WALK,
        S_PERIOD,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    state_t             state_q;
    logic [CNT_W-1:0]   step_cnt_q;
    logic [CNT_W-1:0]   per_cnt_q;
    logic [CNT_W-1:0]   step_cnt_d;
    logic [CNT_W-1:0]   per_cnt_d;
    logic               seed_ready_q;
    logic               reset_nos_q;
    logic [N_NODES-1:0] init_state_q;
    logic               res_valid_q;
    logic [CNT_W-1:0]   res_meet_q;
    logic [CNT_W-1:0]   res_period_q;
    logic               res_timeout_q;
    logic [N_NODES-1:0] res_seed_q;

    logic vec_eq;
    logic walk_match;
    logic walk_tmo;
    logic per_match;
    logic per_tmo;
    logic busy;
    logic abort_hit;

    assign vec_eq     = (s0_vec == s1_vec);
    assign walk_match = (state_q == S_WALK) && (step_cnt_q != '0) && !step_cnt_q[0] && vec_eq;
    assign walk_tmo   = (state_q == S_WALK) && !walk_match && (step_cnt_q >= MAX_CNT);
    assign per_match  = (state_q == S_PERIOD) && (per_cnt_q != '0) && vec_eq;
    assign per_tmo    = (state_q == S_PERIOD) && !per_match && (per_cnt_q >= MAX_CNT);
    assign busy       = (state_q == S_LOAD) || (state_q == S_WALK) || (state_q == S_PERIOD);
    assign abort_hit  = abort && busy;

    assign step_cnt_d = (step_cnt_q >= MAX_CNT) ? MAX_CNT : step_cnt_q + CNT_W'(1);
    assign per_cnt_d  = (per_cnt_q >= MAX_CNT) ? MAX_CNT : per_cnt_q + CNT_W'(1);

    // Starts are decoded combinationally so a meet, a limit or an abort stops the nodes in the same cycle.
    assign start_s0 = (state_q == S_WALK) && !walk_match && !walk_tmo && !abort;
    assign start_s1 = start_s0 ||
                      ((state_q == S_PERIOD) && !per_match && !per_tmo && !abort);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            step_cnt_q    <= '0;
            per_cnt_q     <= '0;
            seed_ready_q  <= 1'b0;
            reset_nos_q   <= 1'b0;
            init_state_q  <= '0;
            res_valid_q   <= 1'b0;
            res_meet_q    <= '0;
            res_period_q  <= '0;
            res_timeout_q <= 1'b0;
            res_seed_q    <= '0;
        end else begin
            reset_nos_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    seed_ready_q <= 1'b1;
                    if (seed_valid && seed_ready_q) begin
                        seed_ready_q <= 1'b0;
                        res_seed_q   <= seed;
                        init_state_q <= seed;
                        reset_nos_q  <= 1'b1;
                        state_q      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    step_cnt_q    <= '0;
                    per_cnt_q     <= '0;
                    res_meet_q    <= '0;
                    res_period_q  <= '0;
                    res_timeout_q <= 1'b0;
                    if (abort_hit) begin
                        seed_ready_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        state_q <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (abort_hit) begin
                        seed_ready_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else if (walk_match) begin
                        res_meet_q <= step_cnt_q;
                        state_q    <= S_PERIOD;
                    end else if (walk_tmo) begin
                        res_meet_q    <= MAX_CNT;
                        res_period_q  <= '0;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        step_cnt_q <= step_cnt_d;
                    end
                end
                S_PERIOD: begin
                    if (abort_hit) begin
                        seed_ready_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else if (per_match) begin
                        res_period_q  <= per_cnt_q;
                        res_timeout_q <= 1'b0;
                        res_valid_q   <= 1'b1;
                        state_q       <= S_DONE;
                    end else if (per_tmo) begin
                        res_period_q  <= '0;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        per_cnt_q <= per_cnt_d;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid_q  <= 1'b0;
                        seed_ready_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    seed_ready_q <= 1'b0;
                    res_valid_q  <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign seed_ready  = seed_ready_q;
    assign reset_nos   = reset_nos_q;
    assign init_state  = init_state_q;
    assign res_valid   = res_valid_q;
    assign res_meet    = res_meet_q;
    assign res_period  = res_period_q;
    assign res_timeout = res_timeout_q;
    assign res_seed    = res_seed_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench for gnr_attractor_ctrl with a 4-node behavioural network whose
// update rule (identity, invert, increment) is selectable per run.
module tb_gnr_attractor_ctrl;

    logic        clk;
    logic        rst_n;
    logic        seed_valid;
    logic        seed_ready;
    logic [3:0]  seed;
    logic        abort;
    logic        reset_nos;
    logic [3:0]  init_state;
    logic        start_s0;
    logic        start_s1;
    logic [3:0]  s0_vec;
    logic [3:0]  s1_vec;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_meet;
    logic [15:0] res_period;
    logic        res_timeout;
    logic [3:0]  res_seed;

    int checks = 0;
    int errors = 0;

    logic [1:0] mode;
    logic       pass_q;

    int s0_total = 0;
    int s1_total = 0;
    int rv_total = 0;
    int overlap_total = 0;

    gnr_attractor_ctrl #(
        .N_NODES  (4),
        .CNT_W    (16),
        .MAX_STEPS(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed       (seed),
        .abort      (abort),
        .reset_nos  (reset_nos),
        .init_state (init_state),
        .start_s0   (start_s0),
        .start_s1   (start_s1),
        .s0_vec     (s0_vec),
        .s1_vec     (s1_vec),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_meet   (res_meet),
        .res_period (res_period),
        .res_timeout(res_timeout),
        .res_seed   (res_seed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] nxt(input logic [1:0] m, input logic [3:0] x);
        case (m)
            2'd0:    return x;
            2'd1:    return ~x;
            default: return x + 4'd1;
        endcase
    endfunction

    // Hare advances on every start_s1; tortoise advances on every second start_s0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vec <= '0;
            s1_vec <= '0;
            pass_q <= 1'b0;
        end else if (reset_nos) begin
            s0_vec <= init_state;
            s1_vec <= init_state;
            pass_q <= 1'b0;
        end else begin
            if (start_s1) s1_vec <= nxt(mode, s1_vec);
            if (start_s0) begin
                pass_q <= ~pass_q;
                if (pass_q) s0_vec <= nxt(mode, s0_vec);
            end
        end
    end

    always @(negedge clk) begin
        if (start_s0 === 1'b1) s0_total++;
        if (start_s1 === 1'b1) s1_total++;
        if (res_valid === 1'b1) rv_total++;
        if (reset_nos === 1'b1 && (start_s0 === 1'b1 || start_s1 === 1'b1)) overlap_total++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_seed(input logic [3:0] s);
        int n;
        n = 0;
        while (seed_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("seed_ready_wait", 32'(seed_ready), 32'd1);
        seed       = s;
        seed_valid = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (res_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic finish_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int s0_base;
        int s1_base;
        int rv_base;

        rst_n      = 1'b0;
        seed_valid = 1'b0;
        seed       = '0;
        abort      = 1'b0;
        res_ready  = 1'b0;
        mode       = 2'd0;

        repeat (3) @(negedge clk);
        check("rst_seed_ready", 32'(seed_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_reset_nos", 32'(reset_nos), 32'd0);
        check("rst_starts", 32'({start_s0, start_s1}), 32'd0);
        check("rst_init_state", 32'(init_state), 32'd0);
        check("rst_res_meet", 32'(res_meet), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check("seed_ready_after_rst", 32'(seed_ready), 32'd1);

        // Fixed point: next = x
        mode    = 2'd0;
        s0_base = s0_total;
        s1_base = s1_total;
        send_seed(4'b1010);
        check("load_reset_nos", 32'(reset_nos), 32'd1);
        check("load_seed_ready", 32'(seed_ready), 32'd0);
        check("load_init_state", 32'(init_state), 32'hA);
        check("load_starts", 32'({start_s0, start_s1}), 32'd0);
        wait_res(lat);
        check("fp_latency", 32'(lat), 32'd6);
        check("fp_meet", 32'(res_meet), 32'd2);
        check("fp_period", 32'(res_period), 32'd1);
        check("fp_timeout", 32'(res_timeout), 32'd0);
        check("fp_seed", 32'(res_seed), 32'hA);
        check("fp_s0_steps", 32'(s0_total - s0_base), 32'd2);
        check("fp_s1_steps", 32'(s1_total - s1_base), 32'd3);

        for (int i = 0; i < 5; i++) begin
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_seed_ready", 32'(seed_ready), 32'd0);
            check("hold_meet", 32'(res_meet), 32'd2);
            check("hold_period", 32'(res_period), 32'd1);
            check("hold_seed", 32'(res_seed), 32'hA);
            abort = (i == 2);
            @(negedge clk);
        end
        abort = 1'b0;
        check("hold_after_abort_valid", 32'(res_valid), 32'd1);
        finish_res();
        check("release_res_valid", 32'(res_valid), 32'd0);
        check("release_seed_ready", 32'(seed_ready), 32'd1);

        // Oscillator: next = ~x
        mode    = 2'd1;
        s0_base = s0_total;
        s1_base = s1_total;
        send_seed(4'b0000);
        wait_res(lat);
        check("osc_latency", 32'(lat), 32'd9);
        check("osc_meet", 32'(res_meet), 32'd4);
        check("osc_period", 32'(res_period), 32'd2);
        check("osc_timeout", 32'(res_timeout), 32'd0);
        check("osc_seed", 32'(res_seed), 32'h0);
        check("osc_s0_steps", 32'(s0_total - s0_base), 32'd4);
        check("osc_s1_steps", 32'(s1_total - s1_base), 32'd6);
        finish_res();

        // Counter: next = x+1, walk limit of 8 steps
        mode    = 2'd2;
        s0_base = s0_total;
        s1_base = s1_total;
        send_seed(4'b0011);
        wait_res(lat);
        check("cnt_latency", 32'(lat), 32'd10);
        check("cnt_timeout", 32'(res_timeout), 32'd1);
        check("cnt_meet", 32'(res_meet), 32'd8);
        check("cnt_period", 32'(res_period), 32'd0);
        check("cnt_s0_steps", 32'(s0_total - s0_base), 32'd8);
        check("cnt_s1_steps", 32'(s1_total - s1_base), 32'd8);
        finish_res();

        // Abort at walk step 3
        mode    = 2'd2;
        rv_base = rv_total;
        send_seed(4'b0101);
        repeat (4) @(negedge clk);
        check("abort_pre_start_s0", 32'(start_s0), 32'd1);
        abort = 1'b1;
        #1;
        check("abort_start_s0", 32'(start_s0), 32'd0);
        check("abort_start_s1", 32'(start_s1), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_seed_ready", 32'(seed_ready), 32'd1);
        repeat (5) @(negedge clk);
        check("abort_no_result", 32'(rv_total - rv_base), 32'd0);

        mode = 2'd0;
        send_seed(4'b0110);
        wait_res(lat);
        check("post_abort_latency", 32'(lat), 32'd6);
        check("post_abort_meet", 32'(res_meet), 32'd2);
        check("post_abort_period", 32'(res_period), 32'd1);
        check("post_abort_seed", 32'(res_seed), 32'h6);
        finish_res();

        // Reset mid-PERIOD
        mode    = 2'd1;
        rv_base = rv_total;
        send_seed(4'b0000);
        repeat (6) @(negedge clk);
        check("period_start_s1", 32'(start_s1), 32'd1);
        check("period_start_s0", 32'(start_s0), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_seed_ready", 32'(seed_ready), 32'd0);
        check("midrst_starts", 32'({start_s0, start_s1}), 32'd0);
        check("midrst_reset_nos", 32'(reset_nos), 32'd0);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_res_meet", 32'(res_meet), 32'd0);
        check("midrst_res_seed", 32'(res_seed), 32'd0);
        check("midrst_init_state", 32'(init_state), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_seed_ready_rise", 32'(seed_ready), 32'd1);
        check("midrst_no_result", 32'(rv_total - rv_base), 32'd0);

        send_seed(4'b0000);
        wait_res(lat);
        check("rerun_latency", 32'(lat), 32'd9);
        check("rerun_meet", 32'(res_meet), 32'd4);
        check("rerun_period", 32'(res_period), 32'd2);
        check("rerun_timeout", 32'(res_timeout), 32'd0);
        finish_res();

        check("no_load_start_overlap", 32'(overlap_total), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gnr_attractor_ctrl.md
GNR_ATTRACTOR_CTRL -- requirements
Module: gnr_attractor_ctrl

Interface
REQ-001 SHALL have parameter N_NODES, default 8: number of network nodes, and the width of the seed and state vectors.
REQ-002 SHALL have parameter CNT_W, default 16: width of the step and period counters.
REQ-003 SHALL have parameter MAX_STEPS, default 1000: walk-step limit, applied separately to each phase.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port seed_valid, input, 1 bit, and seed_ready, output, 1 bit: valid/ready handshake for a seed.
REQ-007 SHALL have port seed, input, N_NODES bits: initial network state.
REQ-008 SHALL have port abort, input, 1 bit: synchronous cancel of the current search.
REQ-009 SHALL have port reset_nos, output, 1 bit: load pulse to all nodes.
REQ-010 SHALL have port init_state, output, N_NODES bits: per-node load value.
REQ-011 SHALL have ports start_s0 and start_s1, output, 1 bit each: node step enables.
REQ-012 SHALL have ports s0_vec and s1_vec, input, N_NODES bits each: concatenated node s0/s1 outputs, registered in the nodes.
REQ-013 SHALL have ports res_valid, output, 1 bit, and res_ready, input, 1 bit: valid/ready handshake for a result.
REQ-014 SHALL have port res_meet, output, CNT_W bits: hare steps taken to the first meet.
REQ-015 SHALL have port res_period, output, CNT_W bits: attractor period.
REQ-016 SHALL have port res_timeout, output, 1 bit: set when a step limit is hit.
REQ-017 SHALL have port res_seed, output, N_NODES bits: the seed that produced this result.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD, WALK, PERIOD and DONE.
REQ-019 IDLE SHALL drive seed_ready=1; on seed_valid&&seed_ready it SHALL capture seed into res_seed and init_state, then go to LOAD.
REQ-020 LOAD SHALL last exactly 1 cycle, assert reset_nos=1, clear step_cnt and per_cnt, then go to WALK.
REQ-021 In WALK, the node state SHALL reflect step_cnt steps.
REQ-022 In WALK, match SHALL be defined as step_cnt!=0 && step_cnt[0]==0 && s0_vec==s1_vec.
REQ-023 In WALK without match, start_s0=start_s1=1 and step_cnt SHALL increment; s1 advances every step and s0 advances every second step (node pass behaviour).
REQ-024 In WALK on match, both starts SHALL be 0, res_meet SHALL take step_cnt, and the FSM SHALL go to PERIOD.
REQ-025 In PERIOD, only start_s1 SHALL be asserted and per_cnt SHALL increment each cycle.
REQ-026 In PERIOD, when per_cnt!=0 && s0_vec==s1_vec, start_s1 SHALL be 0, res_period SHALL take per_cnt, res_timeout SHALL be 0, and the FSM SHALL go to DONE.
REQ-027 In WALK, when step_cnt reaches MAX_STEPS with no match, the FSM SHALL go to DONE with res_timeout=1 and res_meet=MAX_STEPS.
REQ-028 In PERIOD, when per_cnt reaches MAX_STEPS with no match, the FSM SHALL go to DONE with res_timeout=1 and res_period=0.
REQ-029 DONE SHALL drive res_valid=1 with all res_* held stable; on res_ready the FSM SHALL go to IDLE.
REQ-030 res_valid SHALL not depend combinationally on res_ready.
REQ-031 seed_ready SHALL be 0 in every state except IDLE.
REQ-032 abort in LOAD, WALK or PERIOD SHALL deassert all starts in that cycle and go to IDLE next cycle, with no result.
REQ-033 abort SHALL be ignored in IDLE and DONE.
REQ-034 reset_nos and the starts SHALL never be asserted together.
REQ-035 start_s0 and start_s1 SHALL be 0 outside WALK and PERIOD.
REQ-036 Counters SHALL saturate at MAX_STEPS and never wrap.
REQ-037 Latency from seed accept to res_valid SHALL be 1 (LOAD) + res_meet + 1 + per_cnt + 1 cycles.

Reset
REQ-038 rst_n low SHALL immediately force the FSM to IDLE and all outputs to 0: seed_ready, reset_nos, starts, res_*, init_state.
REQ-039 seed_ready SHALL rise in the first clock cycle after rst_n deasserts.
REQ-040 rst_n assertion in any state, including mid-PERIOD, SHALL discard the search with no res_valid.

Verification (N_NODES=4, behavioural node model)
REQ-041 Fixed point, next=x, seed 4'b1010 -> res_meet=2, res_period=1, res_timeout=0, res_seed=4'b1010.
REQ-042 Oscillator, next=~x, seed 4'b0000 -> res_meet=4, res_period=2, res_timeout=0.
REQ-043 Counter, next=x+1 mod 16, MAX_STEPS=8 -> res_timeout=1, res_meet=8, no start asserted after step 8.
REQ-044 Hold res_ready=0 for 5 cycles in DONE -> res_valid=1 and res_* stable throughout, seed_ready=0; one cycle after res_ready=1, seed_ready=1.
REQ-045 abort at WALK step 3 -> no starts that cycle, IDLE the next cycle, res_valid never rises, next seed processed normally.
REQ-046 rst_n low mid-PERIOD -> all outputs 0 at once; after release, the oscillator seed rerun gives res_period=2.
